i2c_fifo_slave_p: RTL and testbench
===================================

I2C_FIFO_SLAVE_P -- requirements
Module: i2c_fifo_slave_p

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h19, 7-bit address matched against the I2C address byte {addr[6:0], rw}; rw=0 means write, rw=1 means read.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO depth in bytes; legal values are powers of two, 2..256.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops on scl and sda_in.
REQ-004 clk  input  1  system clock; clk SHALL run at 8x or more the SCL rate.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 scl  input  1  I2C clock from the bus.
REQ-007 sda_in  input  1  I2C data as sampled from the bus.
REQ-008 sda_oe  output  1  1 = pull SDA low, 0 = release SDA.
REQ-009 clr  input  1  synchronous FIFO flush that also clears the sticky flags.
REQ-010 fifo_count  output  $clog2(DEPTH)+1  bytes currently stored.
REQ-011 fifo_full, fifo_empty  output  1 each  FIFO status flags.
REQ-012 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-013 SHALL synchronise scl and sda_in through SYNC_STAGES flops, then detect scl rising/falling edges on the synchronised signals.
REQ-014 START (sda falling while scl high) SHALL enter ADDR from any state, including mid-byte; a repeated START is handled the same way.
REQ-015 STOP (sda rising while scl high) SHALL enter IDLE from any state and release sda_oe.
REQ-016 States SHALL be IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-017 Bit sampling: bits SHALL be sampled MSB first on scl rise.
REQ-018 Output timing: sda_oe SHALL change only after an scl fall, within SYNC_STAGES+2 clk cycles of it.
REQ-019 Address handling: when the 8th address bit is sampled, a match SHALL go to ADDR_ACK and drive an ACK (sda_oe=1) for one SCL period.
REQ-020 Address mismatch: SHALL go to IGNORE with sda_oe held 0 until the next START or STOP.
REQ-021 Write: each complete byte received in WR_DATA SHALL be pushed on the 8th scl rise when not full, then ACKed in WR_ACK.
REQ-022 Write when full: the byte SHALL be discarded and NACKed (sda_oe=0), and overflow SHALL be set.
REQ-023 Read load: on entry to RD_DATA, the head byte SHALL be popped into the shift register.
REQ-024 Read when empty: 8'hFF SHALL be loaded instead and underflow SHALL be set.
REQ-025 Read transmit: the slave SHALL drive the bit-inverse onto sda_oe (0 bit -> oe=1).
REQ-026 Read continuation: in RD_ACK, a master ACK SHALL return to RD_DATA with the next pop; a master NACK SHALL go to IGNORE.
REQ-027 A partial byte ended by START or STOP SHALL be discarded and SHALL NOT be pushed.
REQ-028 Flags: fifo_full = (count==DEPTH) and fifo_empty = (count==0); both SHALL be registered and valid the cycle after a push or pop.
REQ-029 Pointers SHALL wrap modulo DEPTH; count SHALL NOT exceed DEPTH or go below 0.
REQ-030 A push and pop in the same cycle is not possible by protocol and SHALL NOT be handled.
REQ-031 clr SHALL take priority over a same-cycle push or pop, zeroing pointers, count and sticky flags; the bus state machine SHALL be unaffected.

Reset
REQ-032 rst SHALL immediately force: state=IDLE, sda_oe=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0, underflow=0, and all synchroniser flops to 1 (idle bus).
REQ-033 rst during a transfer SHALL release SDA at once; the next transaction SHALL require a fresh START.

Configuration
REQ-034 With I2C_FIFO_GENERAL_CALL_EN defined: address byte 8'h00 SHALL be ACKed, and a following data byte 8'h55 SHALL be ACKed and flush the FIFO as clr does; any other byte SHALL be NACKed with no effect.
REQ-035 Without I2C_FIFO_GENERAL_CALL_EN: address 8'h00 SHALL be treated as a mismatch.

Structure
REQ-036 Package i2c_pkg SHALL hold the state enum typedef, ACK/NACK constants and the read-empty filler constant 8'hFF.
REQ-037 The FIFO storage, pointers, count and flags SHALL be one sub-module named sync_fifo_p (parameters DEPTH, WIDTH=8), instantiated once.

Verification
REQ-038 Write 8'h32 then 8'h2F, STOP, then 8'h32 then 8'hAE, STOP -> 4 ACKs observed, fifo_count=2.
REQ-039 Then 8'h33, read two bytes (ACK then NACK), STOP -> bytes 8'h2F then 8'hAE on SDA; fifo_empty=1.
REQ-040 Write 17 bytes 8'h00..8'h10 with DEPTH=16 -> first 16 ACKed, 17th NACKed; overflow=1, fifo_full=1; a subsequent read returns 8'h00 first.
REQ-041 Address 8'h40 -> no ACK, sda_oe stays 0 through the STOP; then 8'h33 on an empty FIFO -> returns 8'hFF, underflow=1.
REQ-042 START, address 8'h32, 4 data bits, then STOP -> fifo_count unchanged, state IDLE; rst asserted mid read byte -> sda_oe=0 in the same cycle.
REQ-043 With I2C_FIFO_GENERAL_CALL_EN: 3 bytes stored, then 8'h00 followed by 8'h55 -> both ACKed, fifo_count=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C FIFO slave.
// Bus state enum, ACK/NACK bus levels and the read-empty filler byte.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  // SDA levels as seen on the bus
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [7:0] RD_FILL  = 8'hFF;
  localparam logic [7:0] GC_ADDR  = 8'h00;
  localparam logic [7:0] GC_FLUSH = 8'h55;

endpackage

// File: rtl/sync_fifo_p.sv
// Byte FIFO with registered full/empty and sticky overflow/underflow.
// clr has priority over push and pop and also clears the sticky flags.
module sync_fifo_p #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q & ~clr_i;
  assign do_pop  = pop_i & ~empty_q & ~clr_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | (push_i & full_q);
    unf_d  = unf_q | (pop_i & empty_q);
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end else if (do_push) begin
      wptr_d = wptr_q + AW'(1);
      cnt_d  = cnt_q + (AW+1)'(1);
    end else if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
      cnt_d  = cnt_q - (AW+1)'(1);
    end
    full_d  = (cnt_d == FULL_CNT);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o     = mem_q[rptr_q];
  assign count_o     = cnt_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: rtl/i2c_fifo_slave_p.sv
// I2C slave: writes push into a byte FIFO, reads pop from it.
// Define I2C_FIFO_GENERAL_CALL_EN to accept general call 8'h55 as a flush.
module i2c_fifo_slave_p
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h19,
  parameter int         DEPTH       = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scl,
  input  logic                   sda_in,
  output logic                   sda_oe,
  input  logic                   clr,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   overflow,
  output logic                   underflow
);

`ifdef I2C_FIFO_GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_s, sda_s, scl_p_q, sda_p_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  i2c_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       oe_q, oe_d;
  logic       ph_q, ph_d;
  logic       ack_q, ack_d;
  logic       rw_q, rw_d;
  logic       gc_q, gc_d;

  logic       push, pop, gc_clr;
  logic [7:0] byte_in, load, rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q[0] <= scl;
      sda_sync_q[0] <= sda_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_p_q <= scl_s;
      sda_p_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p_q;
  assign scl_fall  = ~scl_s & scl_p_q;
  assign start_det = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop_det  = scl_s & scl_p_q & ~sda_p_q & sda_s;

  assign byte_in = {sh_q[6:0], sda_s};
  assign load    = fifo_empty ? RD_FILL : rdata;

  // ph_q marks that the ninth (ACK) rise has been seen
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    oe_d    = oe_q;
    ph_d    = ph_q;
    ack_d   = ack_q;
    rw_d    = rw_q;
    gc_d    = gc_q;
    push    = 1'b0;
    pop     = 1'b0;
    gc_clr  = 1'b0;
    if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      ph_d    = 1'b0;
      gc_d    = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      gc_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            ph_d = 1'b0;
            if (byte_in[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = byte_in[0];
            end else if (GC_EN && byte_in == GC_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = 1'b0;
              gc_d    = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: if (scl_rise) begin
          ph_d = 1'b1;
        end else if (scl_fall) begin
          if (!ph_q) begin
            oe_d = ~ACK;
          end else if (rw_q) begin
            state_d = RD_DATA;
            cnt_d   = '0;
            pop     = 1'b1;
            sh_d    = load;
            oe_d    = ~load[7];
          end else begin
            state_d = WR_DATA;
            cnt_d   = '0;
            oe_d    = 1'b0;
          end
        end
        WR_DATA: if (scl_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = WR_ACK;
            ph_d    = 1'b0;
            if (gc_q) begin
              ack_d  = (byte_in == GC_FLUSH);
              gc_clr = (byte_in == GC_FLUSH);
            end else begin
              ack_d = ~fifo_full;
              push  = 1'b1;
            end
          end
        end
        WR_ACK: if (scl_rise) begin
          ph_d = 1'b1;
        end else if (scl_fall) begin
          if (!ph_q) begin
            oe_d = ack_q;
          end else begin
            state_d = WR_DATA;
            cnt_d   = '0;
            oe_d    = 1'b0;
          end
        end
        RD_DATA: if (scl_rise) begin
          cnt_d = cnt_q + 4'd1;
          sh_d  = {sh_q[6:0], 1'b0};
        end else if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            state_d = RD_ACK;
            oe_d    = 1'b0;
            ph_d    = 1'b0;
          end else begin
            oe_d = ~sh_q[7];
          end
        end
        RD_ACK: if (scl_rise) begin
          ph_d  = 1'b1;
          ack_d = (sda_s == ACK);
        end else if (scl_fall && ph_q) begin
          if (ack_q) begin
            state_d = RD_DATA;
            cnt_d   = '0;
            pop     = 1'b1;
            sh_d    = load;
            oe_d    = ~load[7];
          end else begin
            state_d = IGNORE;
            oe_d    = 1'b0;
          end
        end
        IGNORE: oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      oe_q    <= 1'b0;
      ph_q    <= 1'b0;
      ack_q   <= 1'b0;
      rw_q    <= 1'b0;
      gc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      oe_q    <= oe_d;
      ph_q    <= ph_d;
      ack_q   <= ack_d;
      rw_q    <= rw_d;
      gc_q    <= gc_d;
    end
  end

  assign sda_oe = oe_q;

  sync_fifo_p #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr | gc_clr),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     (sh_d),
    .rdata_o     (rdata),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

endmodule

// File: tb/tb_i2c_fifo_slave_p.sv
// Directed plus randomized bench for i2c_fifo_slave_p.
// A queue-based FIFO model predicts ACKs, read bytes and flags.
module tb_i2c_fifo_slave_p;

  localparam int DEPTH = 16;
  localparam int Q     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_sda;
  logic       sda_in;
  logic       sda_oe;
  logic       clr;
  logic [4:0] fifo_count;
  logic       fifo_full, fifo_empty, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  byte unsigned mq[$];
  bit m_ovf, m_unf;
  bit watch, saw_oe;

  always #5 clk = ~clk;

  assign sda_in = m_sda & ~sda_oe;

  i2c_fifo_slave_p #(
    .SLAVE_ADDR  (7'h19),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .clr        (clr),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always @(negedge clk) if (watch && sda_oe) saw_oe = 1'b1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    scl   = 1'b1; tick(Q);
    m_sda = 1'b1; tick(2 * Q);
  endtask

  task automatic bit_cycle(input logic drv, output logic smp);
    m_sda = drv; tick(Q);
    scl   = 1'b1; tick(Q);
    smp   = sda_in; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, s);
      b = {b[6:0], s};
    end
    bit_cycle(~mack, s);
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic wr_chk(input logic [7:0] b, input string tag);
    logic ack, exp;
    exp = (mq.size() < DEPTH);
    if (exp) mq.push_back(b);
    else m_ovf = 1'b1;
    write_byte(b, ack);
    chk(tag, ack, exp);
  endtask

  task automatic rd_chk(input logic mack, input string tag);
    logic [7:0] b, exp;
    if (mq.size() == 0) begin
      exp   = 8'hFF;
      m_unf = 1'b1;
    end else begin
      exp = mq.pop_front();
    end
    read_byte(mack, b);
    chk(tag, b, exp);
  endtask

  task automatic adr_chk(input logic [7:0] a, input logic exp, input string tag);
    logic ack;
    write_byte(a, ack);
    chk(tag, ack, exp);
  endtask

  task automatic status(input string tag);
    chk({tag, "_cnt"}, fifo_count, mq.size());
    chk({tag, "_full"}, fifo_full, mq.size() == DEPTH);
    chk({tag, "_empty"}, fifo_empty, mq.size() == 0);
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_unf"}, underflow, m_unf);
  endtask

  task automatic pulse_clr();
    clr = 1'b1; tick(1);
    clr = 1'b0; tick(1);
    model_clear();
  endtask

  initial begin
    logic s;
    int n, m;
    rst = 1'b1; scl = 1'b1; m_sda = 1'b1; clr = 1'b0;
    watch = 1'b0; saw_oe = 1'b0;
    model_clear();
    tick(3);
    chk("rst_oe", sda_oe, 1'b0);
    status("rst");
    rst = 1'b0; tick(4);

    i2c_start();
    adr_chk(8'h32, 1'b1, "w1_adr");
    wr_chk(8'h2F, "w1_d0");
    i2c_stop();
    i2c_start();
    adr_chk(8'h32, 1'b1, "w2_adr");
    wr_chk(8'hAE, "w2_d0");
    i2c_stop();
    status("two_wr");

    i2c_start();
    adr_chk(8'h33, 1'b1, "r1_adr");
    rd_chk(1'b1, "r1_b0");
    rd_chk(1'b0, "r1_b1");
    i2c_stop();
    status("two_rd");

    i2c_start();
    adr_chk(8'h32, 1'b1, "fill_adr");
    for (int i = 0; i < 17; i++) wr_chk(8'(i), $sformatf("fill_%0d", i));
    i2c_stop();
    status("fill");
    i2c_start();
    adr_chk(8'h33, 1'b1, "rfull_adr");
    rd_chk(1'b0, "rfull_b0");
    i2c_stop();
    status("rfull");
    pulse_clr();
    status("clr");

    watch = 1'b1; saw_oe = 1'b0;
    i2c_start();
    adr_chk(8'h40, 1'b0, "miss_adr");
    write_byte(8'($urandom), s);
    i2c_stop();
    watch = 1'b0;
    chk("miss_oe", saw_oe, 1'b0);
    i2c_start();
    adr_chk(8'h33, 1'b1, "remp_adr");
    rd_chk(1'b0, "remp_b0");
    i2c_stop();
    status("remp");
    pulse_clr();

    i2c_start();
    adr_chk(8'h32, 1'b1, "part_adr");
    for (int i = 0; i < 4; i++) bit_cycle(1'(i), s);
    i2c_stop();
    chk("part_oe", sda_oe, 1'b0);
    status("part");

    i2c_start();
    adr_chk(8'h32, 1'b1, "z_adr");
    wr_chk(8'h00, "z_d0");
    i2c_stop();
    i2c_start();
    adr_chk(8'h33, 1'b1, "rr_adr");
    for (int i = 0; i < 3; i++) bit_cycle(1'b1, s);
    chk("rr_drive", sda_oe, 1'b1);
    rst = 1'b1;
    #1;
    chk("rr_oe", sda_oe, 1'b0);
    model_clear();
    scl = 1'b1; m_sda = 1'b1;
    tick(3);
    rst = 1'b0; tick(4);
    status("rr");

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 20);
      i2c_start();
      adr_chk(8'h32, 1'b1, $sformatf("rw%0d_adr", r));
      for (int j = 0; j < n; j++) wr_chk(8'($urandom), $sformatf("rw%0d_w%0d", r, j));
      i2c_stop();
      status($sformatf("rw%0d_w", r));
      m = $urandom_range(1, 6);
      i2c_start();
      adr_chk(8'h33, 1'b1, $sformatf("rr%0d_adr", r));
      for (int j = 0; j < m; j++) rd_chk(j != m - 1, $sformatf("rr%0d_r%0d", r, j));
      i2c_stop();
      status($sformatf("rr%0d_r", r));
    end

    pulse_clr();
    i2c_start();
    adr_chk(8'h32, 1'b1, "gc_fill_adr");
    for (int i = 0; i < 3; i++) wr_chk(8'($urandom), $sformatf("gc_fill_%0d", i));
    i2c_stop();
`ifdef I2C_FIFO_GENERAL_CALL_EN
    i2c_start();
    adr_chk(8'h00, 1'b1, "gc_adr");
    adr_chk(8'h12, 1'b0, "gc_other");
    status("gc_other");
    adr_chk(8'h55, 1'b1, "gc_flush");
    i2c_stop();
    model_clear();
    status("gc");
`else
    i2c_start();
    adr_chk(8'h00, 1'b0, "gc_adr");
    i2c_stop();
    status("gc");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
